down_seq: RTL and testbench
===========================

Name: down_seq

Overview:
- Parametrised, sequential successor to the DBUS 64-to-32 down mux.
- Captures one wide bus word and serialises it into narrow beats over a valid/ready handshake.
- Supports a programmable start lane, beat count and lane order (ascending/descending).
- Sits between the wide internal data bus and narrow-width bus cycles: 8/16/32-bit memory, peripheral and cartridge accesses.

Parameters:
- IN_W, 64: wide input width; must equal OUT_W × RATIO, with RATIO a power of two ≥ 2.
- OUT_W, 32: narrow output beat width.
- RATIO, IN_W/OUT_W: derived; not overridable.
- LANE_W, clog2(RATIO): derived lane index width.
- CNT_W, LANE_W+1: derived beat-count width.

Ports:
- sys_clk, in, 1: system clock; all state on its rising edge.
- resetl, in, 1: synchronous active-low reset.
- in_valid, in, 1: wide word and control are valid.
- in_ready, out, 1: block can accept a wide word this cycle.
- din, in, IN_W: wide data. Lane k = din[k*OUT_W +: OUT_W].
- start_lane, in, LANE_W: first lane emitted.
- nbeats, in, CNT_W: number of beats to emit, 1..RATIO.
- descend, in, 1: 0 = lane index increments per beat; 1 = lane index decrements per beat.
- out_valid, out, 1: dout is valid.
- out_ready, in, 1: consumer accepts the beat.
- dout, out, OUT_W: current narrow beat, registered.
- out_lane, out, LANE_W: lane index of the current beat.
- out_last, out, 1: current beat is the final beat of the word.

Behaviour:
- Reset (resetl low at an edge):
  - State goes to IDLE; out_valid=0, out_last=0, out_lane=0, dout=0.
  - Captured word and counters are cleared.
  - in_ready is 0 while resetl is low.
  - Reset mid-word discards all remaining beats; nothing resumes after release.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: out_valid=1.
- Accept: a word is accepted when in_valid && in_ready at an edge. At that edge the block registers din, descend and the effective count, and loads the first beat.
- Latency: first beat appears on dout with out_valid=1 in the cycle after the accept edge.
- Effective count: nbeats=0 or nbeats>RATIO is treated as RATIO.
- Beat advance:
  - A beat completes on out_valid && out_ready.
  - The next lane is (lane+1) mod RATIO, or (lane−1) mod RATIO when descend=1. Wrap-around is required, e.g. start 3, ascending, 2 beats → lanes 3, 0.
  - dout, out_lane and out_last update at that edge.
  - dout, out_lane and out_last hold stable while out_valid && !out_ready.
- out_last is 1 exactly on the beat where the remaining count is 1.
- Word end:
  - When the last beat completes and no new accept occurs, the block returns to IDLE and out_valid drops on the next cycle.
- Back-to-back:
  - in_ready = IDLE || (out_valid && out_ready && out_last).
  - On the edge that completes the last beat, a simultaneous accept loads the new word's first beat. out_valid stays 1 with no bubble.
- Inputs ignored outside accept: din, start_lane, nbeats and descend are ignored except on the accept edge. Changing them while BUSY has no effect.
- Input backpressure: in_valid held high while BUSY (and not on the last beat) is not accepted; the source must hold it.
- Compatibility: with RATIO=2 and nbeats=1, start_lane reproduces the existing down-mux lane selection, registered.

Test Plan:
Benches use IN_W=64, OUT_W=16 and din=64'h1111_2222_3333_4444 (lane0=4444, lane1=3333, lane2=2222, lane3=1111) unless stated.

1. Accept at cycle 0 with start_lane=0, nbeats=4, descend=0, out_ready=1 → cycles 1–4 give dout 4444, 3333, 2222, 1111. out_lane 0..3, out_last only at cycle 4, out_valid=0 at cycle 5.
2. start_lane=3, nbeats=2, descend=0 → beats 1111, 4444 (wrap to lane 0); out_last on the second beat. Then start_lane=1, nbeats=3, descend=1 → beats 3333, 4444, 1111.
3. nbeats=0 → 4 beats emitted. Then nbeats=1, start_lane=2 → single beat 2222 with out_last=1.
4. out_ready toggled 1,0,0,1,1,1 → each beat held stable while stalled. Sequence remains 4444, 3333, 2222, 1111; no beat is lost or duplicated.
5. Second word 64'hAAAA_BBBB_CCCC_DDDD offered with in_valid during the last beat of the first word → accepted on that edge. The next cycle shows DDDD with out_valid continuously 1.
6. resetl driven low for 1 cycle after the second beat → next edge out_valid=0, out_last=0, dout=0, in_ready=0 during reset. After release, in_ready=1 and no stale beats appear.

Source files
------------

// File: rtl/down_seq_if.sv
// Handshake bundle between the wide-word producer and the narrow-beat consumer of down_seq.
interface down_seq_if #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 32
) ();
   localparam int RATIO  = IN_W / OUT_W;
   localparam int LANE_W = $clog2(RATIO);
   localparam int CNT_W  = LANE_W + 1;

   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   din;
   logic [LANE_W-1:0] start_lane;
   logic [CNT_W-1:0]  nbeats;
   logic              descend;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  dout;
   logic [LANE_W-1:0] out_lane;
   logic              out_last;

   modport master (
      output in_valid, din, start_lane, nbeats, descend, out_ready,
      input  in_ready, out_valid, dout, out_lane, out_last
   );

   modport slave (
      input  in_valid, din, start_lane, nbeats, descend, out_ready,
      output in_ready, out_valid, dout, out_lane, out_last
   );
endinterface

// File: rtl/down_seq.sv
// Captures one wide word and serialises it as narrow registered beats with a
// programmable start lane, beat count and lane direction.
module down_seq #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 32
) (
   input  logic       sys_clk,
   input  logic       resetl,
   down_seq_if.slave  bus
);
   localparam int RATIO  = IN_W / OUT_W;
   localparam int LANE_W = $clog2(RATIO);
   localparam int CNT_W  = LANE_W + 1;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef logic [RATIO-1:0][OUT_W-1:0] lanes_t;

   state_t            state_q, state_d;
   lanes_t            data_q, data_d;
   logic              desc_q, desc_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic              last_q, last_d;

   lanes_t            din_lanes;
   logic [CNT_W-1:0]  eff_cnt;
   logic [LANE_W-1:0] nxt_lane;
   logic              beat_done;
   logic              in_rdy;
   logic              accept;

   assign din_lanes = bus.din;
   assign eff_cnt   = ((bus.nbeats == '0) || (bus.nbeats > CNT_W'(RATIO))) ?
                      CNT_W'(RATIO) : bus.nbeats;
   assign beat_done = (state_q == BUSY) && bus.out_ready;
   // The last-beat completion frees the block in the same cycle, so a new word
   // can load its first beat without a bubble.
   assign in_rdy    = resetl && ((state_q == IDLE) || (beat_done && last_q));
   assign accept    = bus.in_valid && in_rdy;
   assign nxt_lane  = desc_q ? (lane_q - LANE_W'(1)) : (lane_q + LANE_W'(1));

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      desc_d  = desc_q;
      rem_d   = rem_q;
      lane_d  = lane_q;
      dout_d  = dout_q;
      last_d  = last_q;
      if (accept) begin
         state_d = BUSY;
         data_d  = din_lanes;
         desc_d  = bus.descend;
         rem_d   = eff_cnt;
         lane_d  = bus.start_lane;
         dout_d  = din_lanes[bus.start_lane];
         last_d  = (eff_cnt == CNT_W'(1));
      end else if (beat_done) begin
         if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
         end else begin
            rem_d  = rem_q - CNT_W'(1);
            lane_d = nxt_lane;
            dout_d = data_q[nxt_lane];
            last_d = (rem_q == CNT_W'(2));
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         state_q <= IDLE;
         data_q  <= '0;
         desc_q  <= 1'b0;
         rem_q   <= '0;
         lane_q  <= '0;
         dout_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         desc_q  <= desc_d;
         rem_q   <= rem_d;
         lane_q  <= lane_d;
         dout_q  <= dout_d;
         last_q  <= last_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = (state_q == BUSY);
   assign bus.dout      = dout_q;
   assign bus.out_lane  = lane_q;
   assign bus.out_last  = last_q;
endmodule

// File: tb/tb_down_seq.sv
// Bench for down_seq (64-bit in, 16-bit beats): vector table, directed corner
// sequences and randomized traffic against a beat-queue reference model.
module tb_down_seq;
   localparam int IN_W  = 64;
   localparam int OUT_W = 16;
   localparam int R     = IN_W / OUT_W;

   logic sys_clk = 1'b0;
   logic resetl;
   always #5 sys_clk = ~sys_clk;

   down_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
   down_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .sys_clk (sys_clk),
      .resetl  (resetl),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] d;
      int          lane;
      logic        last;
   } beat_t;
   beat_t q[$];

   typedef struct {
      int          start;
      int          nb;
      bit          desc;
      int          n;
      logic [15:0] d[4];
      int          ln[4];
   } vec_t;
   vec_t vt[6];

   bit          mon_en   = 1'b0;
   bit          acc_last = 1'b0;
   bit          pat[6];
   logic [15:0] pexp[6];
   logic [63:0] w1 = 64'h1111_2222_3333_4444;
   logic [63:0] w2 = 64'hAAAA_BBBB_CCCC_DDDD;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: beats in order, lane = start +/- i modulo R, count clamped to R.
   function automatic void model_push(input logic [63:0] w, input int start,
                                      input int nb, input bit desc);
      int n;
      int lane;
      beat_t b;
      n = (nb == 0 || nb > R) ? R : nb;
      for (int i = 0; i < n; i++) begin
         lane   = desc ? ((start - i + R) % R) : ((start + i) % R);
         b.d    = w[lane*OUT_W +: OUT_W];
         b.lane = lane;
         b.last = (i == n - 1);
         q.push_back(b);
      end
   endfunction

   always @(negedge sys_clk) begin : monitor
      logic exp_rdy;
      if (mon_en) begin
         chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            chk("dout", 64'(bus.dout), 64'(q[0].d));
            chk("out_lane", 64'(bus.out_lane), 64'(q[0].lane));
            chk("out_last", 64'(bus.out_last), 64'(q[0].last));
         end
         exp_rdy = resetl && ((q.size() == 0) || (bus.out_ready && q[0].last));
         chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         acc_last = bus.in_valid && bus.in_ready;
         if (!resetl) begin
            q.delete();
         end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && exp_rdy)
               model_push(bus.din, int'(bus.start_lane), int'(bus.nbeats), bus.descend);
         end
      end
   end

   task automatic send(input logic [63:0] w, input int st, input int nb, input bit desc);
      bit ok;
      ok = 1'b0;
      @(posedge sys_clk); #1;
      bus.in_valid   = 1'b1;
      bus.din        = w;
      bus.start_lane = 2'(st);
      bus.nbeats     = 3'(nb);
      bus.descend    = desc;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_in_time", 64'(ok), 64'd1);
      @(posedge sys_clk); #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0] = '{0, 4, 1'b0, 4, '{16'h4444, 16'h3333, 16'h2222, 16'h1111}, '{0, 1, 2, 3}};
      vt[1] = '{3, 2, 1'b0, 2, '{16'h1111, 16'h4444, 16'h0, 16'h0}, '{3, 0, 0, 0}};
      vt[2] = '{1, 3, 1'b1, 3, '{16'h3333, 16'h4444, 16'h1111, 16'h0}, '{1, 0, 3, 0}};
      vt[3] = '{2, 0, 1'b1, 4, '{16'h2222, 16'h3333, 16'h4444, 16'h1111}, '{2, 1, 0, 3}};
      vt[4] = '{2, 1, 1'b0, 1, '{16'h2222, 16'h0, 16'h0, 16'h0}, '{2, 0, 0, 0}};
      vt[5] = '{1, 5, 1'b0, 4, '{16'h3333, 16'h2222, 16'h1111, 16'h4444}, '{1, 2, 3, 0}};
      pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      pexp = '{16'h4444, 16'h3333, 16'h3333, 16'h3333, 16'h2222, 16'h1111};

      resetl         = 1'b0;
      bus.in_valid   = 1'b0;
      bus.din        = '0;
      bus.start_lane = '0;
      bus.nbeats     = '0;
      bus.descend    = 1'b0;
      bus.out_ready  = 1'b1;

      @(posedge sys_clk); #1;
      mon_en = 1'b1;
      @(negedge sys_clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_last", 64'(bus.out_last), 64'd0);
      chk("rst_out_lane", 64'(bus.out_lane), 64'd0);
      chk("rst_dout", 64'(bus.dout), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge sys_clk); #1;
      resetl = 1'b1;
      @(negedge sys_clk);
      chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

      foreach (vt[v]) begin
         send(w1, vt[v].start, vt[v].nb, vt[v].desc);
         for (int k = 0; k < vt[v].n; k++) begin
            @(negedge sys_clk);
            chk("vec_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_dout", 64'(bus.dout), 64'(vt[v].d[k]));
            chk("vec_lane", 64'(bus.out_lane), 64'(vt[v].ln[k]));
            chk("vec_last", 64'(bus.out_last), 64'(k == vt[v].n - 1));
            @(posedge sys_clk); #1;
         end
         @(negedge sys_clk);
         chk("vec_end_valid", 64'(bus.out_valid), 64'd0);
      end

      send(w1, 0, 4, 1'b0);
      for (int k = 0; k < 6; k++) begin
         bus.out_ready = pat[k];
         @(negedge sys_clk);
         chk("stall_valid", 64'(bus.out_valid), 64'd1);
         chk("stall_dout", 64'(bus.dout), 64'(pexp[k]));
         @(posedge sys_clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge sys_clk);
      chk("stall_end_valid", 64'(bus.out_valid), 64'd0);

      send(w1, 0, 4, 1'b0);
      bus.in_valid   = 1'b1;
      bus.din        = w2;
      bus.start_lane = 2'd0;
      bus.nbeats     = 3'd4;
      bus.descend    = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         chk("b2b_w1_dout", 64'(bus.dout), 64'(w1[k*16 +: 16]));
         chk("b2b_in_ready", 64'(bus.in_ready), 64'(k == 3));
         @(posedge sys_clk); #1;
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         chk("b2b_valid", 64'(bus.out_valid), 64'd1);
         chk("b2b_w2_dout", 64'(bus.dout), 64'(w2[k*16 +: 16]));
         @(posedge sys_clk); #1;
      end
      @(negedge sys_clk);
      chk("b2b_end_valid", 64'(bus.out_valid), 64'd0);

      send(w1, 0, 4, 1'b0);
      repeat (2) begin
         @(negedge sys_clk);
         @(posedge sys_clk); #1;
      end
      resetl = 1'b0;
      @(negedge sys_clk);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge sys_clk); #1;
      resetl = 1'b1;
      @(negedge sys_clk);
      chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_last", 64'(bus.out_last), 64'd0);
      chk("post_rst_dout", 64'(bus.dout), 64'd0);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (4) begin
         @(negedge sys_clk);
         chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
      end

      for (int c = 0; c < 4000; c++) begin
         @(posedge sys_clk); #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!(bus.in_valid && !acc_last)) begin
            bus.in_valid   = ($urandom_range(0, 2) == 0);
            bus.din        = {$urandom, $urandom};
            bus.start_lane = 2'($urandom);
            bus.nbeats     = 3'($urandom);
            bus.descend    = 1'($urandom);
         end
      end
      @(posedge sys_clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40 && q.size() != 0; c++) begin
         @(posedge sys_clk); #1;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
